// File: rtl/ascii2scancode_pkg.sv
// Shared types for the ASCII-to-PS/2 set-2 typer: break/shift bytes, FSM states,
// lookup result struct and table helpers.
package kb_pkg;
    localparam logic [7:0] SC_BREAK_DEF  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT_DEF = 8'h12;

    typedef enum logic [2:0] {
        IDLE, SH_MAKE, MAKE, BRK_PFX, BRK, SH_BRK_PFX, SH_BRK
    } state_t;

    typedef struct packed {
        logic       supported;
        logic       shift;
        logic [7:0] make;
    } lut_t;

    function automatic lut_t mk(input logic shift, input logic [7:0] code);
        lut_t r;
        r.supported = 1'b1;
        r.shift     = shift;
        r.make      = code;
        return r;
    endfunction

    // Index is the low five ASCII bits, so 'a' and 'A' both map to 1.
    function automatic logic [7:0] letter_make(input logic [4:0] idx);
        case (idx)
            5'd1:  return 8'h1C;  5'd2:  return 8'h32;  5'd3:  return 8'h21;
            5'd4:  return 8'h23;  5'd5:  return 8'h24;  5'd6:  return 8'h2B;
            5'd7:  return 8'h34;  5'd8:  return 8'h33;  5'd9:  return 8'h43;
            5'd10: return 8'h3B;  5'd11: return 8'h42;  5'd12: return 8'h4B;
            5'd13: return 8'h3A;  5'd14: return 8'h31;  5'd15: return 8'h44;
            5'd16: return 8'h4D;  5'd17: return 8'h15;  5'd18: return 8'h2D;
            5'd19: return 8'h1B;  5'd20: return 8'h2C;  5'd21: return 8'h3C;
            5'd22: return 8'h2A;  5'd23: return 8'h1D;  5'd24: return 8'h22;
            5'd25: return 8'h35;  5'd26: return 8'h1A;
            default: return 8'h00;
        endcase
    endfunction
endpackage

// File: rtl/ascii2scancode_if.sv
// Character-in / scancode-out handshake bundle.
interface ascii2scancode_if;
    logic [7:0] i_ascii;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] o_scancode;
    logic       o_valid;
    logic       i_ready;
    logic       o_err;

    modport slave  (input  i_ascii, i_valid, i_ready, output o_ready, o_scancode, o_valid, o_err);
    modport master (output i_ascii, i_valid, i_ready, input  o_ready, o_scancode, o_valid, o_err);
endinterface

// File: rtl/ascii2scancode_lut.sv
// Combinational ASCII -> {supported, shift, make} lookup for the JP set-2 layout.
module ascii2scancode_lut
    import kb_pkg::*;
(
    input  logic [7:0] i_ascii,
    output lut_t       o_lut
);
    always_comb begin
        o_lut = '0;
        if (i_ascii >= 8'h61 && i_ascii <= 8'h7A)
            o_lut = mk(1'b0, letter_make(i_ascii[4:0]));
        else if (i_ascii >= 8'h41 && i_ascii <= 8'h5A)
            o_lut = mk(1'b1, letter_make(i_ascii[4:0]));
        else begin
            case (i_ascii)
                8'h31: o_lut = mk(1'b0, 8'h16);  8'h21: o_lut = mk(1'b1, 8'h16);
                8'h32: o_lut = mk(1'b0, 8'h1E);  8'h22: o_lut = mk(1'b1, 8'h1E);
                8'h33: o_lut = mk(1'b0, 8'h26);  8'h23: o_lut = mk(1'b1, 8'h26);
                8'h34: o_lut = mk(1'b0, 8'h25);  8'h24: o_lut = mk(1'b1, 8'h25);
                8'h35: o_lut = mk(1'b0, 8'h2E);  8'h25: o_lut = mk(1'b1, 8'h2E);
                8'h36: o_lut = mk(1'b0, 8'h36);  8'h26: o_lut = mk(1'b1, 8'h36);
                8'h37: o_lut = mk(1'b0, 8'h3D);  8'h27: o_lut = mk(1'b1, 8'h3D);
                8'h38: o_lut = mk(1'b0, 8'h3E);  8'h28: o_lut = mk(1'b1, 8'h3E);
                8'h39: o_lut = mk(1'b0, 8'h46);  8'h29: o_lut = mk(1'b1, 8'h46);
                8'h30: o_lut = mk(1'b0, 8'h45);
                // JP symbol pairs: unshifted left, shifted right
                8'h2D: o_lut = mk(1'b0, 8'h4E);  8'h3D: o_lut = mk(1'b1, 8'h4E);
                8'h5E: o_lut = mk(1'b0, 8'h55);  8'h7E: o_lut = mk(1'b1, 8'h55);
                8'h5C: o_lut = mk(1'b0, 8'h6A);  8'h7C: o_lut = mk(1'b1, 8'h6A);
                8'h40: o_lut = mk(1'b0, 8'h54);  8'h60: o_lut = mk(1'b1, 8'h54);
                8'h5B: o_lut = mk(1'b0, 8'h5B);  8'h7B: o_lut = mk(1'b1, 8'h5B);
                8'h3B: o_lut = mk(1'b0, 8'h4C);  8'h2B: o_lut = mk(1'b1, 8'h4C);
                8'h3A: o_lut = mk(1'b0, 8'h52);  8'h2A: o_lut = mk(1'b1, 8'h52);
                8'h5D: o_lut = mk(1'b0, 8'h5D);  8'h7D: o_lut = mk(1'b1, 8'h5D);
                8'h2C: o_lut = mk(1'b0, 8'h41);  8'h3C: o_lut = mk(1'b1, 8'h41);
                8'h2E: o_lut = mk(1'b0, 8'h49);  8'h3E: o_lut = mk(1'b1, 8'h49);
                8'h2F: o_lut = mk(1'b0, 8'h4A);  8'h3F: o_lut = mk(1'b1, 8'h4A);
                8'h5F: o_lut = mk(1'b1, 8'h51);
                8'h08: o_lut = mk(1'b0, 8'h66);  8'h0D: o_lut = mk(1'b0, 8'h5A);
                8'h20: o_lut = mk(1'b0, 8'h29);  8'h1B: o_lut = mk(1'b0, 8'h76);
                default: o_lut = '0;
            endcase
        end
    end
endmodule

// File: rtl/ascii2scancode.sv
// Types one ASCII character as a PS/2 set-2 make/break byte stream, wrapping
// shifted characters in left-shift make/break.
module ascii2scancode
    import kb_pkg::*;
#(
    parameter logic [7:0] SC_BREAK  = SC_BREAK_DEF,
    parameter logic [7:0] SC_LSHIFT = SC_LSHIFT_DEF
) (
    input logic              clk,
    input logic              i_rst_n,
    ascii2scancode_if.slave  bus
);
    state_t     state, state_nxt;
    lut_t       lut;
    logic       rdy_en, shift_q, err_q, vld_q;
    logic [7:0] make_q, make_sel, sc_q, sc_nxt;
    logic       accept, adv;

    ascii2scancode_lut u_lut (.i_ascii(bus.i_ascii), .o_lut(lut));

    // rdy_en keeps o_ready low during reset and for the first edge after release
    assign bus.o_ready    = rdy_en && (state == IDLE);
    assign bus.o_valid    = vld_q;
    assign bus.o_scancode = sc_q;
    assign bus.o_err      = err_q;

    assign accept   = bus.i_valid && bus.o_ready;
    assign adv      = vld_q && bus.i_ready;
    assign make_sel = accept ? lut.make : make_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (accept && lut.supported) state_nxt = lut.shift ? SH_MAKE : MAKE;
            SH_MAKE:    if (adv) state_nxt = MAKE;
            MAKE:       if (adv) state_nxt = BRK_PFX;
            BRK_PFX:    if (adv) state_nxt = BRK;
            BRK:        if (adv) state_nxt = shift_q ? SH_BRK_PFX : IDLE;
            SH_BRK_PFX: if (adv) state_nxt = SH_BRK;
            SH_BRK:     if (adv) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase

        // Output byte follows the state being entered so o_scancode is a plain register
        sc_nxt = 8'h00;
        case (state_nxt)
            SH_MAKE, SH_BRK:     sc_nxt = SC_LSHIFT;
            MAKE, BRK:           sc_nxt = make_sel;
            BRK_PFX, SH_BRK_PFX: sc_nxt = SC_BREAK;
            default:             sc_nxt = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            vld_q   <= 1'b0;
            sc_q    <= 8'h00;
            err_q   <= 1'b0;
            rdy_en  <= 1'b0;
            shift_q <= 1'b0;
            make_q  <= 8'h00;
        end else begin
            state  <= state_nxt;
            vld_q  <= (state_nxt != IDLE);
            sc_q   <= sc_nxt;
            err_q  <= accept && !lut.supported;
            rdy_en <= 1'b1;
            if (accept) begin
                shift_q <= lut.shift;
                make_q  <= lut.make;
            end
        end
    end
endmodule

// File: tb/tb_ascii2scancode.sv
// Directed bench for ascii2scancode: reset, plain/shifted sequences, stalls,
// unsupported characters and mid-sequence reset.
module tb_ascii2scancode;
    logic clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    ascii2scancode_if bus();

    ascii2scancode #(.SC_BREAK(8'hF0), .SC_LSHIFT(8'h12)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for o_ready at a falling edge, then presents ch for one rising edge.
    task automatic accept_char(input logic [7:0] ch);
        int k = 0;
        while (!bus.o_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.o_ready) begin
            total_cnt++;
            $display("FAIL accept_timeout ch=%h o_ready=%b want 1", ch, bus.o_ready);
        end
        bus.i_ascii = ch;
        bus.i_valid = 1'b1;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_ascii = 8'h00;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({bus.o_valid, bus.o_scancode, bus.o_err, bus.o_ready} !== 11'b0)
            $display("FAIL reset_outputs got v=%b sc=%h err=%b rdy=%b want all 0",
                     bus.o_valid, bus.o_scancode, bus.o_err, bus.o_ready);
        else pass_cnt++;
        i_rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.o_ready !== 1'b0) $display("FAIL ready_before_edge got %b want 0", bus.o_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0)
            $display("FAIL ready_after_release got rdy=%b v=%b want 1 0", bus.o_ready, bus.o_valid);
        else pass_cnt++;
    endtask

    task automatic test_plain_a();
        logic [7:0] exp [3] = '{8'h1C, 8'hF0, 8'h1C};
        accept_char(8'h61);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (bus.o_valid !== 1'b1 || bus.o_scancode !== exp[i])
                $display("FAIL a_byte%0d got v=%b sc=%h want 1 %h", i, bus.o_valid, bus.o_scancode, exp[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_scancode !== 8'h00)
            $display("FAIL a_idle got rdy=%b v=%b sc=%h want 1 0 00", bus.o_ready, bus.o_valid, bus.o_scancode);
        else pass_cnt++;
    endtask

    task automatic test_shift_A();
        logic [7:0] exp [6] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12};
        accept_char(8'h41);
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (bus.o_valid !== 1'b1 || bus.o_scancode !== exp[i] || bus.o_err !== 1'b0)
                $display("FAIL A_byte%0d got v=%b sc=%h err=%b want 1 %h 0",
                         i, bus.o_valid, bus.o_scancode, bus.o_err, exp[i]);
            else pass_cnt++;
            // stray request mid-sequence must be ignored
            if (i == 1) begin bus.i_ascii = 8'h71; bus.i_valid = 1'b1; end
            if (i == 2) bus.i_valid = 1'b0;
            @(negedge clk);
        end
        total_cnt++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0)
            $display("FAIL A_idle got rdy=%b v=%b want 1 0", bus.o_ready, bus.o_valid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp0 [3] = '{8'h45, 8'hF0, 8'h45};
        logic [7:0] exp1 [6] = '{8'h12, 8'h16, 8'hF0, 8'h16, 8'hF0, 8'h12};
        accept_char(8'h30);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (bus.o_valid !== 1'b1 || bus.o_scancode !== exp0[i])
                $display("FAIL zero_byte%0d got v=%b sc=%h want 1 %h", i, bus.o_valid, bus.o_scancode, exp0[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (bus.o_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", bus.o_ready);
        else pass_cnt++;
        accept_char(8'h21);
        for (int i = 0; i < 6; i++) begin
            total_cnt++;
            if (bus.o_valid !== 1'b1 || bus.o_scancode !== exp1[i])
                $display("FAIL bang_byte%0d got v=%b sc=%h want 1 %h", i, bus.o_valid, bus.o_scancode, exp1[i]);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (bus.o_valid !== 1'b0) $display("FAIL bang_idle got v=%b want 0", bus.o_valid);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        accept_char(8'h7A);
        total_cnt++;
        if (bus.o_valid !== 1'b1 || bus.o_scancode !== 8'h1A)
            $display("FAIL z_byte0 got v=%b sc=%h want 1 1a", bus.o_valid, bus.o_scancode);
        else pass_cnt++;
        @(negedge clk);
        bus.i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total_cnt++;
            if (bus.o_valid !== 1'b1 || bus.o_scancode !== 8'hF0)
                $display("FAIL z_hold%0d got v=%b sc=%h want 1 f0", k, bus.o_valid, bus.o_scancode);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (bus.o_valid !== 1'b1 || bus.o_scancode !== 8'hF0)
            $display("FAIL z_hold3 got v=%b sc=%h want 1 f0", bus.o_valid, bus.o_scancode);
        else pass_cnt++;
        bus.i_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.o_valid !== 1'b1 || bus.o_scancode !== 8'h1A)
            $display("FAIL z_byte2 got v=%b sc=%h want 1 1a", bus.o_valid, bus.o_scancode);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1)
            $display("FAIL z_idle got v=%b rdy=%b want 0 1", bus.o_valid, bus.o_ready);
        else pass_cnt++;
    endtask

    task automatic test_unsupported();
        logic seen_v = 1'b0;
        accept_char(8'h7F);
        total_cnt++;
        if (bus.o_err !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1)
            $display("FAIL bad_pulse got err=%b v=%b rdy=%b want 1 0 1", bus.o_err, bus.o_valid, bus.o_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.o_err !== 1'b0) $display("FAIL bad_pulse_len got err=%b want 0", bus.o_err);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            if (bus.o_valid !== 1'b0) seen_v = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (seen_v !== 1'b0) $display("FAIL bad_no_bytes got o_valid seen=%b want 0", seen_v);
        else pass_cnt++;
    endtask

    task automatic test_mapping();
        logic [7:0] chs   [9] = '{8'h0D, 8'h20, 8'h08, 8'h1B, 8'h5F, 8'h3F, 8'h7E, 8'h40, 8'h3D};
        logic       shf   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] mks   [9] = '{8'h5A, 8'h29, 8'h66, 8'h76, 8'h51, 8'h4A, 8'h55, 8'h54, 8'h4E};
        for (int c = 0; c < 9; c++) begin
            logic [7:0] exp [6];
            int n;
            if (shf[c]) begin
                exp = '{8'h12, mks[c], 8'hF0, mks[c], 8'hF0, 8'h12};
                n = 6;
            end else begin
                exp = '{mks[c], 8'hF0, mks[c], 8'h00, 8'h00, 8'h00};
                n = 3;
            end
            accept_char(chs[c]);
            for (int i = 0; i < n; i++) begin
                total_cnt++;
                if (bus.o_valid !== 1'b1 || bus.o_scancode !== exp[i])
                    $display("FAIL map_%h_byte%0d got v=%b sc=%h want 1 %h",
                             chs[c], i, bus.o_valid, bus.o_scancode, exp[i]);
                else pass_cnt++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic seen_v = 1'b0;
        logic [7:0] exp [3] = '{8'h12, 8'h1C, 8'hF0};
        accept_char(8'h41);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (bus.o_valid !== 1'b1 || bus.o_scancode !== exp[i])
                $display("FAIL rst_byte%0d got v=%b sc=%h want 1 %h", i, bus.o_valid, bus.o_scancode, exp[i]);
            else pass_cnt++;
            if (i < 2) @(negedge clk);
        end
        i_rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.o_valid !== 1'b0 || bus.o_scancode !== 8'h00 || bus.o_ready !== 1'b0)
            $display("FAIL rst_async got v=%b sc=%h rdy=%b want 0 00 0", bus.o_valid, bus.o_scancode, bus.o_ready);
        else pass_cnt++;
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0)
            $display("FAIL rst_release got rdy=%b v=%b want 1 0", bus.o_ready, bus.o_valid);
        else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            if (bus.o_valid !== 1'b0) seen_v = 1'b1;
            @(negedge clk);
        end
        total_cnt++;
        if (seen_v !== 1'b0) $display("FAIL rst_no_tail got o_valid seen=%b want 0", seen_v);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_plain_a();
        test_shift_A();
        test_back_to_back();
        test_stall();
        test_unsupported();
        test_mapping();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
